// File: rtl/conv_result_streamer.sv
// Drains a captured 7x7 convolution result frame as one pixel per valid/ready beat,
// in raster order, with row/col tags, a last-beat flag and a frame-done pulse.
module conv_result_streamer #(
    parameter int PIX_W   = 8,
    parameter int OUT_DIM = 7,
    parameter int BUS_W   = 648
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BUS_W-1:0]           conv_img,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [PIX_W-1:0]           m_data,
    output logic [$clog2(OUT_DIM)-1:0] m_row,
    output logic [$clog2(OUT_DIM)-1:0] m_col,
    output logic                       m_last,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun
);
    localparam int NPIX = OUT_DIM * OUT_DIM;
    localparam int KW   = $clog2(NPIX);
    localparam int RCW  = $clog2(OUT_DIM);
    localparam logic [KW-1:0]  LAST_K  = KW'(NPIX - 1);
    localparam logic [RCW-1:0] COL_MAX = RCW'(OUT_DIM - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state_reg;
    logic [KW-1:0]    k_reg;
    logic [KW-1:0]    k_next;
    logic [RCW-1:0]   row_reg;
    logic [RCW-1:0]   col_reg;
    logic [PIX_W-1:0] data_reg;
    logic             valid_reg;
    logic             last_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             overrun_reg;
    logic             handshake;
    logic             final_hs;
    logic             capture;
    logic             unused_hi;

    logic [PIX_W-1:0] pix_in  [NPIX];
    logic [PIX_W-1:0] buf_reg [NPIX];

    genvar gi;
    generate
        for (gi = 0; gi < NPIX; gi++) begin : g_pix
            assign pix_in[gi] = conv_img[gi*PIX_W +: PIX_W];
        end
    endgenerate

    // Upper part of the bus carries the unused 9x9 remainder.
    assign unused_hi = ^conv_img[BUS_W-1:NPIX*PIX_W];

    assign handshake = valid_reg && m_ready;
    assign final_hs  = handshake && last_reg;
    // A start is honoured when idle, or exactly on the last handshake (back-to-back frames).
    assign capture   = start && ((state_reg == IDLE) || final_hs);
    assign k_next    = k_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPIX; i++) buf_reg[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < NPIX; i++) buf_reg[i] <= pix_in[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            k_reg       <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            done_reg <= final_hs;
            if (capture)    overrun_reg <= 1'b0;
            else if (start) overrun_reg <= 1'b1;

            if (capture) begin
                // First pixel comes straight from the bus slice so it is ready one cycle after start.
                state_reg <= STREAM;
                k_reg     <= '0;
                row_reg   <= '0;
                col_reg   <= '0;
                data_reg  <= pix_in[0];
                valid_reg <= 1'b1;
                last_reg  <= 1'b0;
                busy_reg  <= 1'b1;
            end else if (state_reg == STREAM && handshake) begin
                if (last_reg) begin
                    state_reg <= IDLE;
                    k_reg     <= '0;
                    row_reg   <= '0;
                    col_reg   <= '0;
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end else begin
                    k_reg    <= k_next;
                    data_reg <= buf_reg[k_next];
                    last_reg <= (k_next == LAST_K);
                    if (col_reg == COL_MAX) begin
                        col_reg <= '0;
                        row_reg <= row_reg + 1'b1;
                    end else begin
                        col_reg <= col_reg + 1'b1;
                    end
                end
            end
        end
    end

    assign m_valid    = valid_reg;
    assign m_data     = data_reg;
    assign m_row      = row_reg;
    assign m_col      = col_reg;
    assign m_last     = last_reg;
    assign busy       = busy_reg;
    assign frame_done = done_reg;
    assign overrun    = overrun_reg;
endmodule

// File: tb/tb_conv_result_streamer.sv
// Bench for conv_result_streamer: a short vector table, directed frame sequences and
// random traffic, all checked against a frame-level queue model.
module tb_conv_result_streamer;
    logic         clk;
    logic         rst;
    logic         start;
    logic [647:0] conv_img;
    logic         m_valid;
    logic         m_ready;
    logic [7:0]   m_data;
    logic [2:0]   m_row;
    logic [2:0]   m_col;
    logic         m_last;
    logic         busy;
    logic         frame_done;
    logic         overrun;

    conv_result_streamer dut (
        .clk(clk), .rst(rst), .start(start), .conv_img(conv_img),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_row(m_row), .m_col(m_col), .m_last(m_last),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [2:0] row;
        logic [2:0] col;
        logic       last;
    } beat_t;

    typedef struct {
        logic       s;
        logic       r;
        logic       v;
        logic [7:0] d;
        logic [2:0] row;
        logic [2:0] col;
        logic       l;
        logic       b;
        logic       fd;
        logic       ov;
    } vec_t;

    int    pass_cnt = 0;
    int    total_cnt = 0;
    int    cyc = 0;
    int    last_hs_cyc = -1;
    int    t0;
    beat_t exp_q[$];
    logic  mdl_busy = 1'b0;
    logic  mdl_ovr = 1'b0;
    int    mdl_rem = 0;
    vec_t  tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        exp_q.delete();
        mdl_busy = 1'b0;
        mdl_ovr  = 1'b0;
        mdl_rem  = 0;
    endtask

    task automatic set_img(input int offset);
        conv_img = '0;
        for (int k = 0; k < 49; k++) conv_img[8*k +: 8] = 8'(k + offset);
    endtask

    // One clock: drive inputs, advance the frame model, then check outputs after the edge.
    task automatic run_cycle(input logic s, input logic r);
        logic  hs;
        logic  done_exp;
        beat_t b;
        start   = s;
        m_ready = r;
        hs       = m_valid && r;
        done_exp = 1'b0;
        if (hs && mdl_busy) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            mdl_rem--;
            if (mdl_rem == 0) begin
                done_exp    = 1'b1;
                mdl_busy    = 1'b0;
                last_hs_cyc = cyc;
            end
        end
        if (s) begin
            if (!mdl_busy) begin
                for (int k = 0; k < 49; k++) begin
                    b.data = conv_img[8*k +: 8];
                    b.row  = 3'(k / 7);
                    b.col  = 3'(k % 7);
                    b.last = (k == 48);
                    exp_q.push_back(b);
                end
                mdl_rem  = 49;
                mdl_busy = 1'b1;
                mdl_ovr  = 1'b0;
            end else begin
                mdl_ovr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("m_valid", 32'(m_valid), 32'(mdl_busy));
        check("busy", 32'(busy), 32'(mdl_busy));
        check("frame_done", 32'(frame_done), 32'(done_exp));
        check("overrun", 32'(overrun), 32'(mdl_ovr));
        if (mdl_busy && exp_q.size() > 0) begin
            b = exp_q[0];
            check("m_data", 32'(m_data), 32'(b.data));
            check("m_row", 32'(m_row), 32'(b.row));
            check("m_col", 32'(m_col), 32'(b.col));
            check("m_last", 32'(m_last), 32'(b.last));
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; m_ready = 1'b0; conv_img = '0;
        tbl[0] = '{1'b1, 1'b0, 1'b1, 8'd1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 8'd1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 8'd2, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 8'd2, 3'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 8'd3, 3'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 8'd4, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1};
        #22;
        check("reset_outputs", {24'd0, m_valid, m_last, busy, frame_done, overrun, 3'd0},
              32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle with no start: m_ready toggling must not disturb anything.
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b0, 1'(i));
            check("idle_zero", {18'd0, m_data, m_row, m_col}, 32'd0);
        end

        // Vector table: start, stall, advance, dropped start.
        set_img(1);
        for (int i = 0; i < 6; i++) begin
            start = tbl[i].s;
            m_ready = tbl[i].r;
            @(posedge clk);
            #1;
            check("tbl_valid", 32'(m_valid), 32'(tbl[i].v));
            check("tbl_data", 32'(m_data), 32'(tbl[i].d));
            check("tbl_row", 32'(m_row), 32'(tbl[i].row));
            check("tbl_col", 32'(m_col), 32'(tbl[i].col));
            check("tbl_last", 32'(m_last), 32'(tbl[i].l));
            check("tbl_busy", 32'(busy), 32'(tbl[i].b));
            check("tbl_done", 32'(frame_done), 32'(tbl[i].fd));
            check("tbl_overrun", 32'(overrun), 32'(tbl[i].ov));
        end
        start = 1'b0;
        pulse_reset();

        // Full-rate frame of 1..49.
        set_img(1);
        t0 = cyc;
        run_cycle(1'b1, 1'b1);
        for (int i = 0; i < 52; i++) run_cycle(1'b0, 1'b1);
        check("fullrate_last_hs", 32'(last_hs_cyc - t0), 32'd49);

        // Ready 1,0,0 repeating: last handshake 147 cycles after start.
        t0 = cyc;
        run_cycle(1'b1, 1'b1);
        for (int i = 1; i < 152; i++) run_cycle(1'b0, 1'(i % 3 == 0));
        check("stall_last_hs", 32'(last_hs_cyc - t0), 32'd147);

        // Bus overwritten with 0xFF after start must not leak into the stream.
        run_cycle(1'b1, 1'b1);
        run_cycle(1'b0, 1'b1);
        conv_img = '1;
        for (int i = 0; i < 50; i++) run_cycle(1'b0, 1'b1);

        // Dropped start mid-frame, then back-to-back start on the final handshake.
        set_img(1);
        run_cycle(1'b1, 1'b1);
        for (int i = 1; i < 49; i++) begin
            if (i == 40) set_img(100);
            run_cycle(1'(i == 10), 1'b1);
        end
        check("overrun_sticky", 32'(overrun), 32'd1);
        run_cycle(1'b1, 1'b1);
        check("b2b_valid", 32'(m_valid), 32'd1);
        check("b2b_first", 32'(m_data), 32'd100);
        check("b2b_overrun_clr", 32'(overrun), 32'd0);
        for (int i = 0; i < 52; i++) run_cycle(1'b0, 1'b1);

        // Asynchronous reset mid-frame at beat 20.
        set_img(1);
        run_cycle(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_outputs",
              {16'd0, m_data, m_valid, m_last, busy, frame_done, overrun, 3'd0}, 32'd0);
        check("async_rst_rowcol", {26'd0, m_row, m_col}, 32'd0);
        model_reset();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b1);
        run_cycle(1'b1, 1'b1);
        check("restart_first", 32'(m_data), 32'd1);
        for (int i = 0; i < 52; i++) run_cycle(1'b0, 1'b1);

        // Random traffic with a bus that changes every cycle.
        for (int i = 0; i < 3000; i++) begin
            for (int j = 0; j < 81; j++) conv_img[8*j +: 8] = 8'($urandom);
            run_cycle(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 9) < 7));
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
